// File: rtl/divu_iterative.sv
// divu_iterative: multi-cycle restoring unsigned divider, one quotient bit per cycle
// Ports: clk/rst (sync active-high); start_valid/start_ready accept {dividend, divisor};
// res_valid/res_ready present {quotient, remainder, div_by_zero}; busy is high in RUN or DONE.
module divu_iterative #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  // Remainder is always below the divisor, so XLEN bits hold it; only the shifted value needs XLEN+1.
  logic [XLEN:0] sh;
  logic ge, go;
  assign start_ready = (state_q == IDLE) & ~rst;
  assign res_valid   = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  always_comb begin
    sh      = {rem_q, quo_q[XLEN-1]};
    ge      = sh >= {1'b0, dvs_q};
    go      = start_valid & start_ready;
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (go) begin
        dvs_d   = divisor;
        dbz_d   = divisor == '0;
        state_d = dbz_d ? DONE : RUN;
        quo_d   = dbz_d ? '1 : dividend;
        rem_d   = dbz_d ? dividend : '0;
        cnt_d   = CW'(XLEN - 1);
      end
      RUN: begin
        rem_d   = ge ? XLEN'(sh - {1'b0, dvs_q}) : sh[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], ge};
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? DONE : RUN;
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end
endmodule

// File: tb/tb_divu_iterative.sv
// tb_divu_iterative: directed and random checks of divu_iterative against a plain-arithmetic model
module tb_divu_iterative;
  logic clk = 0, rst = 1, start_valid = 0, res_ready = 0;
  logic [63:0] dividend = '0, divisor = '0;
  logic start_ready, res_valid, div_by_zero, busy;
  logic [63:0] quotient, remainder;
  int total = 0, bad = 0;

  divu_iterative #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor), .res_valid(res_valid), .res_ready(res_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (!start_ready && n < 200) begin
      tick();
      n++;
    end
    check("start_ready", start_ready, 1);
    dividend = a;
    divisor = b;
    start_valid = 1;
    tick();
    start_valid = 0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] eq, er;
    eq = (b == 0) ? '1 : a / b;
    er = (b == 0) ? a : a % b;
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, b == 0);
    if (b != 0) begin
      check({tag, "_ident"}, quotient * b + remainder, a);
      check({tag, "_rlt"}, remainder < b, 1);
    end
  endtask

  task automatic consume(input int hold);
    repeat (hold) tick();
    res_ready = 1;
    tick();
    res_ready = 0;
    check("post_valid", res_valid, 0);
    check("post_ready", start_ready, 1);
  endtask

  task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b, input int hold);
    int lat;
    start(a, b);
    wait_res(lat);
    check({tag, "_lat"}, lat, (b == 0) ? 0 : 64);
    check_res(tag, a, b);
    consume(hold);
  endtask

  initial begin
    int lat, seen;
    logic [63:0] a, b;
    tick();
    tick();
    check("rst_start_ready", start_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 0;
    #1;
    check("idle_ready", start_ready, 1);

    run_one("d100_7", 100, 7, 0);
    run_one("dz", 64'hDEAD_BEEF, 0, 0);
    run_one("ones_1", '1, 1, 1);
    run_one("ones_ones", '1, '1, 0);
    run_one("d5_9", 5, 9, 2);

    start(1000, 3);
    repeat (5) tick();
    check("run_busy", busy, 1);
    check("run_ready", start_ready, 0);
    dividend = 77;
    divisor = 5;
    start_valid = 1;
    res_ready = 1;
    tick();
    tick();
    start_valid = 0;
    res_ready = 0;
    wait_res(lat);
    check("bp_lat", lat, 64 - 7);
    for (int i = 0; i < 10; i++) begin
      start_valid = i[0];
      dividend = 11;
      divisor = 0;
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_quo", quotient, 333);
      check("bp_hold_rem", remainder, 1);
      check("bp_hold_ready", start_ready, 0);
      tick();
    end
    start_valid = 0;
    check_res("bp", 1000, 3);
    consume(0);
    check("bp_idle_busy", busy, 0);

    start(100, 7);
    repeat (29) tick();
    check("mid_busy", busy, 1);
    rst = 1;
    tick();
    check("mid_rst_ready", start_ready, 0);
    rst = 0;
    #1;
    check("mid_busy0", busy, 0);
    check("mid_ready1", start_ready, 1);
    check("mid_valid0", res_valid, 0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (res_valid) seen++;
      tick();
    end
    check("mid_no_result", seen, 0);
    run_one("d9_2", 9, 2, 0);

    for (int i = 0; i < 500; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = 0;
        1: b = 64'($urandom_range(1, 20));
        2: b = {$urandom, $urandom};
        3: b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: begin
          b = {$urandom, $urandom} >> $urandom_range(32, 63);
          a = a >> $urandom_range(0, 40);
        end
      endcase
      run_one("rnd", a, b, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
